// File: rtl/wreg_pingpong.sv
// Double-buffered weight register file: rows stream into the shadow bank while the
// active bank drives out; a swap commits a complete shadow set atomically.
module wreg_pingpong #(
    parameter int DIM_OUT = 16,
    parameter int DIM_IN  = 110,
    parameter int INWD    = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic                             ld_valid,
    output logic                             ld_ready,
    input  logic [DIM_IN*INWD-1:0]           ld_row,
    input  logic                             swap,
    output logic                             swap_err,
    output logic                             shadow_full,
    output logic                             out_valid,
    output logic [DIM_OUT*DIM_IN*INWD-1:0]   out
);

    localparam int ROW_W = DIM_IN * INWD;
    localparam int PTR_W = $clog2(DIM_OUT);

    logic [PTR_W-1:0] row_ptr_q, row_ptr_d;
    logic             shadow_full_q, shadow_full_d;
    logic             act_sel_q, act_sel_d;
    logic             out_valid_q, out_valid_d;
    logic             swap_err_q, swap_err_d;
    logic             accept;
    logic             swap_ok;

    assign ld_ready    = !shadow_full_q && !clr;
    assign accept      = ld_valid && ld_ready;
    assign swap_ok     = swap && shadow_full_q && !clr;
    assign shadow_full = shadow_full_q;
    assign out_valid   = out_valid_q;
    assign swap_err    = swap_err_q;

    // clr outranks swap; accept and swap_ok are exclusive since accept needs an empty shadow
    always_comb begin
        row_ptr_d     = row_ptr_q;
        shadow_full_d = shadow_full_q;
        act_sel_d     = act_sel_q;
        out_valid_d   = out_valid_q;
        swap_err_d    = swap && !shadow_full_q && !clr;
        if (clr) begin
            row_ptr_d     = '0;
            shadow_full_d = 1'b0;
        end else if (swap_ok) begin
            act_sel_d     = ~act_sel_q;
            shadow_full_d = 1'b0;
            out_valid_d   = 1'b1;
        end else if (accept) begin
            if (row_ptr_q == PTR_W'(DIM_OUT - 1)) begin
                row_ptr_d     = '0;
                shadow_full_d = 1'b1;
            end else begin
                row_ptr_d = row_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_ptr_q     <= '0;
            shadow_full_q <= 1'b0;
            act_sel_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            swap_err_q    <= 1'b0;
        end else begin
            row_ptr_q     <= row_ptr_d;
            shadow_full_q <= shadow_full_d;
            act_sel_q     <= act_sel_d;
            out_valid_q   <= out_valid_d;
            swap_err_q    <= swap_err_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIM_OUT; gi++) begin : g_row
            logic [ROW_W-1:0] bank_a_q;
            logic [ROW_W-1:0] bank_b_q;
            logic             wr_en;

            assign wr_en = accept && (row_ptr_q == PTR_W'(gi));

            // Only the bank not selected by act_sel is ever written
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    bank_a_q <= '0;
                    bank_b_q <= '0;
                end else if (wr_en) begin
                    if (act_sel_q) begin
                        bank_a_q <= ld_row;
                    end else begin
                        bank_b_q <= ld_row;
                    end
                end
            end

            assign out[gi*ROW_W +: ROW_W] = act_sel_q ? bank_b_q : bank_a_q;
        end
    endgenerate

endmodule
